// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - AXI4 INCR burst initiator driven by a one-command-at-a-time local port
module axi4_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_lasterr,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);
    localparam logic [2:0] BEAT_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [2:0] {IDLE, WADDR, WDATA_S, WRESP, RADDR, RDATA_S} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic                  err_seen;
    logic [1:0]            err_resp;
    logic                  last_cnt;
    logic                  w_hs;
    logic                  r_hs;

    assign AWADDR = addr_q;
    assign ARADDR = addr_q;
    assign AWLEN  = len_q;
    assign ARLEN  = len_q;
    assign AWSIZE = BEAT_SIZE;
    assign ARSIZE = BEAT_SIZE;

    assign last_cnt = (beat_cnt == len_q);

    // Data channels are pure passthroughs gated by state, so a beat costs no extra cycle.
    assign WVALID   = (state == WDATA_S) && wr_valid;
    assign WDATA    = wr_data;
    assign WLAST    = (state == WDATA_S) && last_cnt;
    assign wr_ready = (state == WDATA_S) && WREADY;
    assign w_hs     = WVALID && WREADY;

    assign RREADY   = (state == RDATA_S) && rd_ready;
    assign rd_valid = (state == RDATA_S) && RVALID;
    assign rd_data  = RDATA;
    assign rd_last  = (state == RDATA_S) && (RLAST || last_cnt);
    assign r_hs     = rd_valid && rd_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state        <= IDLE;
            cmd_ready    <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            beat_cnt     <= '0;
            err_seen     <= 1'b0;
            err_resp     <= 2'b00;
            AWVALID      <= 1'b0;
            ARVALID      <= 1'b0;
            BREADY       <= 1'b0;
            done         <= 1'b0;
            done_resp    <= 2'b00;
            done_lasterr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is still low during the done cycle, so the next accept comes after it.
                    done <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        addr_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        beat_cnt  <= '0;
                        err_seen  <= 1'b0;
                        err_resp  <= 2'b00;
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            AWVALID <= 1'b1;
                            state   <= WADDR;
                        end else begin
                            ARVALID <= 1'b1;
                            state   <= RADDR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WADDR: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        state   <= WDATA_S;
                    end
                end
                WDATA_S: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (last_cnt) begin
                            BREADY <= 1'b1;
                            state  <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (BVALID) begin
                        BREADY       <= 1'b0;
                        done         <= 1'b1;
                        done_resp    <= BRESP;
                        done_lasterr <= 1'b0;
                        state        <= IDLE;
                    end
                end
                RADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        state   <= RDATA_S;
                    end
                end
                RDATA_S: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (!err_seen && RRESP != 2'b00) begin
                            err_seen <= 1'b1;
                            err_resp <= RRESP;
                        end
                        // Stop on whichever of RLAST or the local count comes first; disagreement is flagged.
                        if (RLAST || last_cnt) begin
                            done         <= 1'b1;
                            done_resp    <= err_seen ? err_resp : RRESP;
                            done_lasterr <= RLAST ^ last_cnt;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- AXI4 initiator that drives the memory-mapped slave's five channels (AW/W/B/AR/R) on behalf of a simple local command port.
- Accepts one burst command at a time (read or write, INCR, full-width beats).
- For writes, streams the payload from a local write-data port. For reads, returns data on a local read-data port.
- Reports completion status per burst.
- Serves as the bus-side driver for integration tests and for future on-chip agents.

Parameters:
DATA_WIDTH, 32, width of WDATA/RDATA and local data ports
ADDR_WIDTH, 16, width of AWADDR/ARADDR and cmd_addr

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_WIDTH  burst start byte address
cmd_len  in  8  beats minus one (0..255)
wr_data  in  DATA_WIDTH  write payload beat
wr_valid  in  1  payload beat available
wr_ready  out  1  payload beat consumed
rd_data  out  DATA_WIDTH  read beat (RDATA passthrough)
rd_valid  out  1  read beat valid
rd_last  out  1  final read beat of burst
rd_ready  in  1  local sink ready for read beat
done  out  1  one-cycle pulse at burst completion
done_resp  out  2  burst response (00 OKAY, 10 SLVERR, ...)
done_lasterr  out  1  RLAST/beat-count mismatch on read burst
AWADDR AWLEN AWSIZE AWVALID  out  ADDR_WIDTH/8/3/1  write address channel
AWREADY  in  1
WDATA WLAST WVALID  out  DATA_WIDTH/1/1  write data channel
WREADY  in  1
BRESP BVALID  in  2/1  write response channel
BREADY  out  1
ARADDR ARLEN ARSIZE ARVALID  out  ADDR_WIDTH/8/3/1  read address channel
ARREADY  in  1
RDATA RRESP RLAST RVALID  in  DATA_WIDTH/2/1/1  read data channel
RREADY  out  1

Behaviour:
- Clock and reset: clocked on ACLK. ARESETn is asynchronous and active-low.
- Reset state:
  - FSM enters IDLE.
  - All VALID/READY outputs, done, done_lasterr and rd_valid are 0.
  - Address/len regs are 0; done_resp is 00.
  - Beat counter is 0 and the error latch is cleared.
- Reset mid-burst: outputs drop to 0 immediately (asynchronously). The burst is abandoned with no done pulse.
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE:
  - cmd_ready=1.
  - A cmd_valid&&cmd_ready cycle latches addr and len, clears the beat counter and error latch.
  - Next state is WADDR if cmd_write=1, else RADDR.
- Fixed outputs: AWSIZE = ARSIZE = log2(DATA_WIDTH/8) (3'b010 for 32). AWLEN/ARLEN = latched len. AWADDR/ARADDR = latched addr.
- WADDR:
  - AWVALID=1, held stable until AWREADY.
  - The handshake cycle moves to WDATA.
  - No W beats are issued before AW completes.
- WDATA:
  - Combinational: WVALID=wr_valid, WDATA=wr_data, wr_ready=WREADY.
  - WLAST = (beat_cnt==len).
  - Each WVALID&&WREADY increments beat_cnt.
  - The handshake with WLAST=1 moves to WRESP.
  - wr_ready=0 in all other states.
- WRESP:
  - BREADY=1.
  - On BVALID: done=1 for one cycle, done_resp=BRESP (held until next done), done_lasterr=0. Next state is IDLE.
- RADDR: ARVALID=1, held stable until ARREADY, then move to RDATA.
- RDATA:
  - RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA.
  - rd_last = RLAST || (beat_cnt==len).
  - On each RVALID&&RREADY: increment beat_cnt. The first non-OKAY RRESP is latched; later beats do not overwrite it.
- Read termination:
  - Terminate on the handshake where RLAST=1 or beat_cnt==len.
  - At termination: done pulse; done_resp = latched error, else 00. done_lasterr=1 if exactly one of RLAST and (beat_cnt==len) is true.
  - Next state is IDLE.
- cmd_len=0: single-beat burst; WLAST is asserted on the first beat.
- Only one outstanding burst. cmd_ready stays 0 until the done cycle has passed (earliest new accept is the cycle after done).
- No address arithmetic is done by the master. The slave owns boundary and range checks; their responses propagate unchanged via done_resp.

Test Plan:
- Write, addr=0x0010, len=3, wr_data 0xA0..0xA3, slave READY always high -> AWLEN=3, AWSIZE=2, four W beats, WLAST on 4th only, done 1 cycle after B handshake, done_resp=00.
- Read, addr=0x0010, len=3, after above write -> rd_data 0xA0..0xA3, rd_last on 4th beat, done_resp=00, done_lasterr=0.
- Backpressure: AWREADY delayed 3 cycles, WREADY toggling, rd_ready low 2 cycles mid-read -> AWVALID/ARVALID stay high and AWADDR stable while waiting; no beat lost or duplicated; beat counts exact.
- Error responses: slave returns BRESP=10 on a write; RRESP=10 on beat 1 of a 4-beat read, OKAY on the rest -> done_resp=10 in both cases.
- RLAST mismatch: len=3 read where the slave asserts RLAST on beat 2 -> burst ends after 2 beats, done pulse, done_lasterr=1.
- ARESETn deasserted during the 2nd W beat of a len=7 write -> all VALIDs 0 asynchronously, no done pulse; after release, cmd_ready=1 and a new len=0 write completes with WLAST on its first beat.
